baseline_hit_trigger: RTL and testbench
=======================================

# baseline_hit_trigger

Consumes the settled baseline and `done` flag from the baseline measurement block, together with the same 14-bit ADC sample stream. It subtracts the baseline from each sample and discriminates pulses against a threshold. For each qualified pulse it publishes a hit record (start timestamp, width, peak, integrated charge) through a single-entry valid/ready output register. It sits between the ADC front end and the hit readout/comms path.

## Interface
- `THRESH`, 20: excess (counts above baseline) at or above which a sample is "over".
- `MIN_WIDTH`, 2: minimum over-threshold samples for a pulse to be published.
- `MAXLEN`, 255: maximum pulse width (1..255); reaching it force-terminates the pulse.
- `DEADTIME`, 16: cycles spent ignoring input after a published pulse.

- `clk` in 1: sample clock; one ADC sample per cycle.
- `rst_n` in 1: reset; asynchronous, active-low.
- `indata` in 14: unsigned ADC sample.
- `baseline` in 14: unsigned baseline from the measurement block.
- `bl_done` in 1: baseline valid; level signal.
- `hit_ready` in 1: downstream accepts the record.
- `hit_valid` out 1: hit record valid.
- `hit_time` out 32: timestamp of the first over sample.
- `hit_width` out 8: number of over samples.
- `hit_peak` out 14: maximum excess in the pulse.
- `hit_charge` out 22: sum of excess over the pulse.
- `hit_sat` out 1: pulse terminated by MAXLEN.
- `lost_cnt` out 16: qualified hits dropped because the output register was full; saturates at 0xFFFF.
- `busy` out 1: FSM is in PULSE or DEAD.

## Operation
- **Input stage, every edge:** `excess_q` = (`indata` > `bl_hold`) ? `indata` − `bl_hold` : 0. Result is 14 bits unsigned and cannot underflow. `ts_q` is a copy of the free-running 32-bit `ts_cnt`, which wraps silently. `over` = (`excess_q` ≥ `THRESH`).
- **`bl_hold`:** loads `baseline` every cycle except in PULSE, where it is frozen.
- **FSM states:** WAIT_BL, IDLE, PULSE, DEAD.
  - **WAIT_BL:** go to IDLE when `bl_done`=1.
  - **IDLE:** if `over`, go to PULSE and set width=1, charge=`excess_q`, peak=`excess_q`, t0=`ts_q`.
  - **PULSE, `over` and width<MAXLEN:** width+1, charge+=`excess_q`, peak=max(peak, `excess_q`).
  - **PULSE, `!over`:** end the pulse. If width ≥ MIN_WIDTH, publish and go to DEAD; otherwise discard and go to IDLE. The terminating sample is not accumulated.
  - **PULSE, `over` and width=MAXLEN:** publish with `hit_sat`=1 and go to DEAD. The current sample is not accumulated.
  - **DEAD:** count DEADTIME cycles, then go to IDLE. Samples are ignored. If input is still over on return to IDLE, a new pulse starts.
  - **Any state:** if `bl_done`=0, go to WAIT_BL. An in-progress pulse is aborted and not published. The output register is unaffected.
- **Publish:** if `hit_valid`=0 or (`hit_valid` & `hit_ready`) in the same cycle, load the record and set `hit_valid`=1. Otherwise drop the hit and increment `lost_cnt` (saturating).
- **Handshake:** `hit_valid` holds, with the record stable, until a cycle with `hit_ready`=1. It then clears unless a new publish loads the register in that same cycle.
- **Widths:** `hit_charge` max 255×16383 < 2^22, so no overflow.

## Timing
- **Reset values:** all outputs 0; state WAIT_BL; `ts_cnt`, `bl_hold` and counters 0.
- **Pulse start:** first over sample presented before edge k is registered at edge k. PULSE is entered at edge k+1, and `hit_time` equals `ts_cnt` at edge k−1.
- **Pulse end:** first under sample presented before edge m. `hit_valid` rises at edge m+1 (2-cycle latency). DEAD starts at edge m+1 and IDLE is re-entered at edge m+1+DEADTIME.
- **MIN_WIDTH:** a pulse of width < MIN_WIDTH returns to IDLE at edge m+1 with no deadtime.
- **Simultaneous publish and accept:** the new record replaces the old one, `hit_valid` stays 1, and `lost_cnt` does not change.
- **Reset mid-pulse:** immediate return to reset values. No partial record is published.

## Test plan
- **Basic pulse:** baseline=1000, `bl_done`=1, samples 1010,1030,1050,1040,1025,1005,1000… → one hit with width=4, peak=50, charge=145, `hit_sat`=0. `hit_valid` rises 2 edges after 1005 is presented.
- **Glitch rejection:** single sample 1030 surrounded by 1000 → no `hit_valid`; FSM back in IDLE, no deadtime.
- **Deadtime:** second pulse starting 5 cycles after the first ends (DEADTIME=16) → ignored. The same pulse starting 20 cycles after the end → published.
- **Backpressure:** `hit_ready`=0 throughout, two qualified pulses → first record held unchanged, `lost_cnt`=1. Then `hit_ready`=1 for one cycle → `hit_valid` drops.
- **Saturation:** MAXLEN=8, input constant at 1100 → width=8, charge=800, peak=100, `hit_sat`=1. A new hit begins after DEADTIME.
- **Baseline gating / underflow:** `bl_done`=0 with large samples → no hits. Raise `bl_done` and drop it mid-pulse → pulse aborted, state WAIT_BL. Samples 900 with baseline 1000 → excess 0, no trigger.

Source files
------------

// File: rtl/baseline_hit_trigger.sv
// Baseline-subtracting pulse discriminator: qualifies over-threshold pulses
// and publishes one hit record at a time through a valid/ready register.
module baseline_hit_trigger #(
    parameter int unsigned THRESH    = 20,
    parameter int unsigned MIN_WIDTH = 2,
    parameter int unsigned MAXLEN    = 255,
    parameter int unsigned DEADTIME  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] indata,
    input  logic [13:0] baseline,
    input  logic        bl_done,
    input  logic        hit_ready,
    output logic        hit_valid,
    output logic [31:0] hit_time,
    output logic [7:0]  hit_width,
    output logic [13:0] hit_peak,
    output logic [21:0] hit_charge,
    output logic        hit_sat,
    output logic [15:0] lost_cnt,
    output logic        busy
);

    localparam logic [13:0] THRESH_C    = 14'(THRESH);
    localparam logic [7:0]  MIN_WIDTH_C = 8'(MIN_WIDTH);
    localparam logic [7:0]  MAXLEN_C    = 8'(MAXLEN);
    localparam int          DT_W        = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DT_W-1:0] DT_LAST_C = DT_W'(DEADTIME - 1);

    typedef enum logic [1:0] {
        ST_WAIT_BL = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PULSE   = 2'd2,
        ST_DEAD    = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;

    logic [31:0]     ts_cnt_r;
    logic [31:0]     ts_q_r;
    logic [13:0]     bl_hold_r;
    logic [13:0]     excess_r;
    logic [13:0]     excess_s;
    logic            over_s;

    logic [7:0]      width_r;
    logic [7:0]      width_nx_s;
    logic [21:0]     charge_r;
    logic [21:0]     charge_nx_s;
    logic [13:0]     peak_r;
    logic [13:0]     peak_nx_s;
    logic [31:0]     t0_r;
    logic [31:0]     t0_nx_s;
    logic [DT_W-1:0] dead_cnt_r;
    logic [DT_W-1:0] dead_cnt_nx_s;

    logic            publish_s;
    logic            pub_sat_s;
    logic            load_s;

    logic            hit_valid_r;
    logic [31:0]     hit_time_r;
    logic [7:0]      hit_width_r;
    logic [13:0]     hit_peak_r;
    logic [21:0]     hit_charge_r;
    logic            hit_sat_r;
    logic [15:0]     lost_cnt_r;
    logic            busy_r;

    // Clamped baseline subtraction; samples below baseline give zero excess
    always_comb begin
        excess_s = 14'd0;
        if (indata > bl_hold_r) begin
            excess_s = indata - bl_hold_r;
        end else begin
            excess_s = 14'd0;
        end
    end

    assign over_s = (excess_r >= THRESH_C);

    // Input stage: timestamp counter, registered excess and baseline hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_r  <= 32'd0;
            ts_q_r    <= 32'd0;
            excess_r  <= 14'd0;
            bl_hold_r <= 14'd0;
        end else begin
            ts_cnt_r <= ts_cnt_r + 32'd1;
            ts_q_r   <= ts_cnt_r;
            excess_r <= excess_s;
            // Baseline is frozen while a pulse is being measured
            if (state_r != ST_PULSE) begin
                bl_hold_r <= baseline;
            end else begin
                bl_hold_r <= bl_hold_r;
            end
        end
    end

    // Next-state and pulse accumulation logic
    always_comb begin
        state_nx_s    = state_r;
        width_nx_s    = width_r;
        charge_nx_s   = charge_r;
        peak_nx_s     = peak_r;
        t0_nx_s       = t0_r;
        dead_cnt_nx_s = dead_cnt_r;
        publish_s     = 1'b0;
        pub_sat_s     = 1'b0;

        if (!bl_done) begin
            state_nx_s = ST_WAIT_BL;
        end else begin
            case (state_r)
                ST_WAIT_BL: begin
                    state_nx_s = ST_IDLE;
                end
                ST_IDLE: begin
                    if (over_s) begin
                        state_nx_s  = ST_PULSE;
                        width_nx_s  = 8'd1;
                        charge_nx_s = {8'd0, excess_r};
                        peak_nx_s   = excess_r;
                        t0_nx_s     = ts_q_r;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (!over_s) begin
                        if (width_r >= MIN_WIDTH_C) begin
                            publish_s     = 1'b1;
                            state_nx_s    = ST_DEAD;
                            dead_cnt_nx_s = {DT_W{1'b0}};
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else if (width_r < MAXLEN_C) begin
                        width_nx_s  = width_r + 8'd1;
                        charge_nx_s = charge_r + {8'd0, excess_r};
                        if (excess_r > peak_r) begin
                            peak_nx_s = excess_r;
                        end else begin
                            peak_nx_s = peak_r;
                        end
                    end else begin
                        // Force-terminate; the current sample is not accumulated
                        publish_s     = 1'b1;
                        pub_sat_s     = 1'b1;
                        state_nx_s    = ST_DEAD;
                        dead_cnt_nx_s = {DT_W{1'b0}};
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_r == DT_LAST_C) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        dead_cnt_nx_s = dead_cnt_r + {{(DT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nx_s = ST_WAIT_BL;
                end
            endcase
        end
    end

    assign load_s = publish_s & (~hit_valid_r | hit_ready);

    // FSM state and pulse accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_WAIT_BL;
            width_r    <= 8'd0;
            charge_r   <= 22'd0;
            peak_r     <= 14'd0;
            t0_r       <= 32'd0;
            dead_cnt_r <= {DT_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            width_r    <= width_nx_s;
            charge_r   <= charge_nx_s;
            peak_r     <= peak_nx_s;
            t0_r       <= t0_nx_s;
            dead_cnt_r <= dead_cnt_nx_s;
            busy_r     <= (state_nx_s == ST_PULSE) || (state_nx_s == ST_DEAD);
        end
    end

    // Single-entry output register with valid/ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid_r  <= 1'b0;
            hit_time_r   <= 32'd0;
            hit_width_r  <= 8'd0;
            hit_peak_r   <= 14'd0;
            hit_charge_r <= 22'd0;
            hit_sat_r    <= 1'b0;
        end else if (load_s) begin
            hit_valid_r  <= 1'b1;
            hit_time_r   <= t0_r;
            hit_width_r  <= width_r;
            hit_peak_r   <= peak_r;
            hit_charge_r <= charge_r;
            hit_sat_r    <= pub_sat_s;
        end else if (hit_ready) begin
            hit_valid_r <= 1'b0;
        end else begin
            hit_valid_r <= hit_valid_r;
        end
    end

    // Saturating count of qualified hits that found the register full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt_r <= 16'd0;
        end else if (publish_s && !load_s && (lost_cnt_r != 16'hFFFF)) begin
            lost_cnt_r <= lost_cnt_r + 16'd1;
        end else begin
            lost_cnt_r <= lost_cnt_r;
        end
    end

    assign hit_valid  = hit_valid_r;
    assign hit_time   = hit_time_r;
    assign hit_width  = hit_width_r;
    assign hit_peak   = hit_peak_r;
    assign hit_charge = hit_charge_r;
    assign hit_sat    = hit_sat_r;
    assign lost_cnt   = lost_cnt_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_baseline_hit_trigger.sv
// Directed self-checking bench for baseline_hit_trigger (MAXLEN reduced to 8).
module tb_baseline_hit_trigger;

    logic        clk;
    logic        rst_n;
    logic [13:0] indata;
    logic [13:0] baseline;
    logic        bl_done;
    logic        hit_ready;
    logic        hit_valid;
    logic [31:0] hit_time;
    logic [7:0]  hit_width;
    logic [13:0] hit_peak;
    logic [21:0] hit_charge;
    logic        hit_sat;
    logic [15:0] lost_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;
    int t0;
    int kk;
    logic seen;

    baseline_hit_trigger #(
        .THRESH(20), .MIN_WIDTH(2), .MAXLEN(8), .DEADTIME(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .indata(indata), .baseline(baseline),
        .bl_done(bl_done), .hit_ready(hit_ready), .hit_valid(hit_valid),
        .hit_time(hit_time), .hit_width(hit_width), .hit_peak(hit_peak),
        .hit_charge(hit_charge), .hit_sat(hit_sat), .lost_cnt(lost_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // present one sample, then sample outputs 1 time unit after the edge
    task automatic cyc(input logic [13:0] s);
        indata = s;
        @(posedge clk);
        #1;
        ecount++;
    endtask

    initial begin
        rst_n = 1'b0; bl_done = 1'b0; indata = 14'd0; baseline = 14'd0; hit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", hit_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_lost", lost_cnt, 0);
        check("rst_time", hit_time, 0);
        check("rst_charge", hit_charge, 0);
        rst_n = 1'b1;
        ecount = 0;

        // no baseline yet: large samples must not trigger
        baseline = 14'd1000;
        repeat (5) cyc(14'd2000);
        check("gate_valid", hit_valid, 0);
        check("gate_busy", busy, 0);
        bl_done = 1'b1;
        repeat (3) cyc(14'd1000);
        check("idle_busy", busy, 0);

        // basic pulse
        cyc(14'd1010);
        t0 = ecount;
        cyc(14'd1030); cyc(14'd1050); cyc(14'd1040); cyc(14'd1025); cyc(14'd1005);
        check("basic_latency", hit_valid, 0);
        cyc(14'd1000);
        check("basic_valid", hit_valid, 1);
        check("basic_width", hit_width, 4);
        check("basic_peak", hit_peak, 50);
        check("basic_charge", hit_charge, 145);
        check("basic_sat", hit_sat, 0);
        check("basic_time", hit_time, t0);
        check("basic_busy", busy, 1);
        hit_ready = 1'b1;
        cyc(14'd1000);
        hit_ready = 1'b0;
        check("basic_accept", hit_valid, 0);
        repeat (14) cyc(14'd1000);
        check("dead_last", busy, 1);
        cyc(14'd1000);
        check("dead_exit", busy, 0);

        // single-sample glitch
        cyc(14'd1030);
        cyc(14'd1000);
        check("glitch_pulse", busy, 1);
        cyc(14'd1000);
        check("glitch_idle", busy, 0);
        check("glitch_valid", hit_valid, 0);

        // width exactly MIN_WIDTH
        t0 = ecount;
        cyc(14'd1030); cyc(14'd1040); cyc(14'd1000); cyc(14'd1000);
        check("minw_valid", hit_valid, 1);
        check("minw_width", hit_width, 2);
        check("minw_charge", hit_charge, 70);
        check("minw_peak", hit_peak, 40);
        check("minw_time", hit_time, t0);
        hit_ready = 1'b1;
        cyc(14'd1000);
        hit_ready = 1'b0;
        repeat (16) cyc(14'd1000);

        // deadtime: pulse 5 cycles after end ignored, 20 cycles after published
        hit_ready = 1'b1;
        cyc(14'd1050); cyc(14'd1050); cyc(14'd1050); cyc(14'd1000);
        cyc(14'd1000);
        check("dt_first", hit_valid, 1);
        repeat (3) cyc(14'd1000);
        seen = 1'b0;
        repeat (3) begin cyc(14'd1050); seen = seen | hit_valid; end
        repeat (12) begin cyc(14'd1000); seen = seen | hit_valid; end
        check("dt_ignored", seen, 0);
        hit_ready = 1'b0;
        t0 = ecount;
        cyc(14'd1060); cyc(14'd1060); cyc(14'd1000); cyc(14'd1000);
        check("dt_second", hit_valid, 1);
        check("dt_second_time", hit_time, t0);
        check("dt_second_peak", hit_peak, 60);
        hit_ready = 1'b1;
        cyc(14'd1000);
        hit_ready = 1'b0;
        repeat (17) cyc(14'd1000);

        // backpressure: second hit dropped, first held
        t0 = ecount;
        cyc(14'd1030); cyc(14'd1030); cyc(14'd1030); cyc(14'd1000); cyc(14'd1000);
        check("bp_first", hit_valid, 1);
        repeat (20) cyc(14'd1000);
        cyc(14'd1080); cyc(14'd1080); cyc(14'd1000); cyc(14'd1000);
        check("bp_lost", lost_cnt, 1);
        check("bp_held_valid", hit_valid, 1);
        check("bp_held_width", hit_width, 3);
        check("bp_held_time", hit_time, t0);
        check("bp_held_charge", hit_charge, 90);
        check("bp_held_peak", hit_peak, 30);
        repeat (20) cyc(14'd1000);

        // publish in the same cycle as accept replaces the record
        t0 = ecount;
        cyc(14'd1070); cyc(14'd1070); cyc(14'd1070); cyc(14'd1070); cyc(14'd1000);
        hit_ready = 1'b1;
        cyc(14'd1000);
        hit_ready = 1'b0;
        check("simul_valid", hit_valid, 1);
        check("simul_width", hit_width, 4);
        check("simul_charge", hit_charge, 280);
        check("simul_time", hit_time, t0);
        check("simul_lost", lost_cnt, 1);
        hit_ready = 1'b1;
        cyc(14'd1000);
        hit_ready = 1'b0;
        check("final_accept", hit_valid, 0);
        repeat (17) cyc(14'd1000);

        // saturation at MAXLEN with constant input
        t0 = ecount;
        cyc(14'd1100);
        kk = ecount;
        while (ecount < kk + 8) cyc(14'd1100);
        check("sat_pre", hit_valid, 0);
        cyc(14'd1100);
        check("sat_valid", hit_valid, 1);
        check("sat_width", hit_width, 8);
        check("sat_charge", hit_charge, 800);
        check("sat_peak", hit_peak, 100);
        check("sat_flag", hit_sat, 1);
        check("sat_time", hit_time, t0);
        hit_ready = 1'b1;
        cyc(14'd1100);
        hit_ready = 1'b0;
        check("sat_accept", hit_valid, 0);
        while (ecount < kk + 24) cyc(14'd1100);
        check("sat_dead", busy, 1);
        cyc(14'd1100);
        check("sat_idle", busy, 0);
        while (ecount < kk + 33) cyc(14'd1100);
        check("sat2_pre", hit_valid, 0);
        cyc(14'd1100);
        check("sat2_valid", hit_valid, 1);
        check("sat2_time", hit_time, t0 + 25);
        check("sat2_flag", hit_sat, 1);
        hit_ready = 1'b1;
        cyc(14'd1000);
        hit_ready = 1'b0;
        repeat (18) cyc(14'd1000);
        check("sat_lost", lost_cnt, 1);

        // bl_done dropped mid-pulse aborts without publishing
        cyc(14'd1100); cyc(14'd1100); cyc(14'd1100);
        check("abort_pre", busy, 1);
        bl_done = 1'b0;
        cyc(14'd1100);
        check("abort_busy", busy, 0);
        repeat (10) cyc(14'd1100);
        check("abort_valid", hit_valid, 0);
        check("abort_lost", lost_cnt, 1);

        // samples below baseline give zero excess
        bl_done = 1'b1;
        repeat (6) cyc(14'd900);
        check("under_valid", hit_valid, 0);
        check("under_busy", busy, 0);

        // asynchronous reset mid-pulse
        cyc(14'd1100); cyc(14'd1100); cyc(14'd1100);
        check("rst2_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_busy", busy, 0);
        check("rst2_valid", hit_valid, 0);
        check("rst2_lost", lost_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
